// File: rtl/falafel_pkg.sv
// Shared falafel definitions: datapath width and memory op encoding.
// Used by the memory-side atomic unit behind the LSU.
package falafel_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MEM_RD  = 2'd0,
        MEM_WR  = 2'd1,
        MEM_CAS = 2'd2
    } mem_op_e;

    // CAS without the write flag degrades to a plain read.
    function automatic mem_op_e mem_decode(
        input logic is_write,
        input logic is_cas
    );
        mem_decode = MEM_RD;
        unique case (1'b1)
            !is_write:           mem_decode = MEM_RD;
            is_write && !is_cas: mem_decode = MEM_WR;
            is_write && is_cas:  mem_decode = MEM_CAS;
            default:             mem_decode = MEM_RD;
        endcase
    endfunction

endpackage

// File: rtl/falafel_mem_atomic_unit.sv
// Memory-side stage: runs LSU read/write/CAS requests against a 1-port SRAM.
// Optional CAS statistics counters: define FALAFEL_MEM_STATS_EN.
module falafel_mem_atomic_unit
    import falafel_pkg::*;
#(
    parameter int SRAM_AW = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mem_req_val_i,
    output logic               mem_req_rdy_o,
    input  logic               mem_req_is_write_i,
    input  logic               mem_req_is_cas_i,
    input  logic [DATA_W-1:0]  mem_req_addr_i,
    input  logic [DATA_W-1:0]  mem_req_data_i,
    input  logic [DATA_W-1:0]  mem_req_cas_exp_i,
    output logic               mem_rsp_val_o,
    input  logic               mem_rsp_rdy_i,
    output logic [DATA_W-1:0]  mem_rsp_data_o,
`ifdef FALAFEL_MEM_STATS_EN
    output logic [31:0]        cas_ok_cnt_o,
    output logic [31:0]        cas_fail_cnt_o,
`endif
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [DATA_W-1:0]  sram_wdata_o,
    input  logic [DATA_W-1:0]  sram_rdata_i
);

    localparam int OFF = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_CAS_WR = 3'd3,
        S_RSP    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    mem_op_e             op_q, op_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [DATA_W-1:0]   rsp_q, rsp_d;

    // Byte-offset and high address bits are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^{mem_req_addr_i[DATA_W-1:SRAM_AW+OFF],
                           mem_req_addr_i[OFF-1:0]};

    assign mem_rsp_data_o = rsp_q;

    // State, request latch and response register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= MEM_RD;
            addr_q  <= '0;
            data_q  <= '0;
            exp_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            exp_q   <= exp_d;
            rsp_q   <= rsp_d;
        end
    end

    // Next state, latch updates and SRAM/handshake outputs.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        exp_d         = exp_q;
        rsp_d         = rsp_q;
        mem_req_rdy_o = 1'b0;
        mem_rsp_val_o = 1'b0;
        sram_req_o    = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = '0;
        sram_wdata_o  = '0;
        case (state_q)
            S_IDLE: begin
                mem_req_rdy_o = 1'b1;
                if (mem_req_val_i) begin
                    op_d    = mem_decode(mem_req_is_write_i,
                                         mem_req_is_cas_i);
                    addr_d  = mem_req_addr_i[SRAM_AW+OFF-1:OFF];
                    data_d  = mem_req_data_i;
                    exp_d   = mem_req_cas_exp_i;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                sram_req_o  = 1'b1;
                sram_addr_o = addr_q;
                if (op_q == MEM_WR) begin
                    sram_we_o    = 1'b1;
                    sram_wdata_o = data_q;
                    rsp_d        = data_q;
                    state_d      = S_RSP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // CAS always reports the old value; LSU compares it.
                rsp_d = sram_rdata_i;
                if (op_q == MEM_CAS && sram_rdata_i == exp_q) begin
                    state_d = S_CAS_WR;
                end else begin
                    state_d = S_RSP;
                end
            end
            S_CAS_WR: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = addr_q;
                sram_wdata_o = data_q;
                state_d      = S_RSP;
            end
            S_RSP: begin
                mem_rsp_val_o = 1'b1;
                if (mem_rsp_rdy_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef FALAFEL_MEM_STATS_EN
    logic [31:0] cas_ok_q;
    logic [31:0] cas_fail_q;
    logic        cas_done;
    logic        cas_hit;

    assign cas_done       = (state_q == S_WAIT) && (op_q == MEM_CAS);
    assign cas_hit        = (sram_rdata_i == exp_q);
    assign cas_ok_cnt_o   = cas_ok_q;
    assign cas_fail_cnt_o = cas_fail_q;

    // Saturating CAS outcome counters, bumped as WAIT resolves a CAS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cas_ok_q   <= '0;
            cas_fail_q <= '0;
        end else if (cas_done) begin
            if (cas_hit && cas_ok_q != 32'hFFFF_FFFF) begin
                cas_ok_q <= cas_ok_q + 32'd1;
            end
            if (!cas_hit && cas_fail_q != 32'hFFFF_FFFF) begin
                cas_fail_q <= cas_fail_q + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/falafel_mem_atomic_unit.md
# falafel_mem_atomic_unit

Memory-side stage directly downstream of the falafel LSU: it consumes the LSU's memory request stream (read / write / compare-and-swap) and executes each request against a single-port synchronous SRAM. CAS is performed atomically as read–compare–conditional-write, with exclusive ownership of the SRAM port. Exactly one response is returned to the LSU per accepted request. One request is in flight at a time.

## Interface
- DATA_W, falafel_pkg::DATA_W, word width; LSU addresses are byte addresses.
- SRAM_AW, 10, SRAM word-address width.
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- mem_req_val_i  in  1  request valid from LSU.
- mem_req_rdy_o  out  1  request ready.
- mem_req_is_write_o… (upstream names) mem_req_is_write_i  in  1  1 = write, 0 = read.
- mem_req_is_cas_i  in  1  1 = CAS; only meaningful when is_write = 1.
- mem_req_addr_i  in  DATA_W  byte address.
- mem_req_data_i  in  DATA_W  write data, or CAS new value.
- mem_req_cas_exp_i  in  DATA_W  CAS expected value.
- mem_rsp_val_o  out  1  response valid.
- mem_rsp_rdy_i  in  1  LSU ready for response.
- mem_rsp_data_o  out  DATA_W  response data.
- sram_req_o  out  1  SRAM access strobe.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  SRAM_AW  SRAM word address.
- sram_wdata_o  out  DATA_W  SRAM write data.
- sram_rdata_i  in  DATA_W  SRAM read data; valid exactly one cycle after a read strobe.

## Operation
- Word address = mem_req_addr_i[SRAM_AW+OFF-1:OFF], where OFF = $clog2(DATA_W/8). The low OFF bits are ignored and are not checked.
- Op decode:
  - READ: is_write = 0.
  - WRITE: is_write = 1, is_cas = 0.
  - CAS: is_write = 1, is_cas = 1.
  - is_cas = 1 with is_write = 0 is treated as READ.
- The request is latched into internal registers on handshake; later changes on the inputs have no effect.
- FSM states: IDLE, ACCESS, WAIT, CAS_WR, RSP.
  - IDLE: mem_req_rdy_o = 1. On val & rdy, latch the request and go to ACCESS.
  - ACCESS: sram_req_o = 1; sram_we_o = 1 only for WRITE. WRITE → RSP with response data = written data. READ/CAS → WAIT.
  - WAIT: capture sram_rdata_i into the response register. CAS with rdata == exp → CAS_WR. Otherwise → RSP.
  - CAS_WR: sram_req_o = 1, sram_we_o = 1, sram_wdata_o = latched data → RSP.
  - RSP: mem_rsp_val_o = 1. When mem_rsp_rdy_i = 1 → IDLE.
- CAS response data is always the old memory value. The LSU determines success by comparing it to exp.
- No new request is accepted until the response handshake completes, which guarantees CAS atomicity.
- SRAM outputs are 0 in every state that does not access the SRAM.

## Timing
- Reset values of outputs:
  - mem_req_rdy_o = 1 (IDLE).
  - All other outputs = 0, including mem_rsp_data_o.
- Latency from the accept edge N to mem_rsp_val_o high:
  - WRITE: N+2.
  - READ: N+3.
  - CAS fail: N+3.
  - CAS success: N+4.
- The response holds stable (val and data) while mem_rsp_rdy_i = 0.
- No combinational path from mem_rsp_rdy_i to mem_req_rdy_o. After a response handshake at edge M, the earliest next accept is edge M+1.
- Reset asserted mid-operation: the FSM returns to IDLE asynchronously and the in-flight request is dropped with no response. A CAS interrupted between WAIT and CAS_WR leaves memory unmodified.
- Back-to-back throughput: WRITE one request per 3 cycles, READ one request per 4 cycles.

## Configuration
- FALAFEL_MEM_STATS_EN
  - Defined: adds output ports cas_ok_cnt_o and cas_fail_cnt_o (32 bits each).
    - Each counter increments by 1 on leaving WAIT for a CAS request (success and failure respectively).
    - Counters saturate at 32'hFFFF_FFFF and are cleared to 0 by rst_i.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- falafel_pkg: DATA_W, and a new mem_op_e enum (MEM_RD, MEM_WR, MEM_CAS) used for the latched op.
- FSM state enum is local to the module.
- No sub-module. A single file implements the FSM, request latch, and response register; the optional counters sit inside an `ifdef` block.

## Test plan
- Reset, then WRITE addr 0x10, data 0xDEADBEEF, with mem_rsp_rdy_i = 1 → sram write to word 4 at N+1; response 0xDEADBEEF at N+2.
- READ addr 0x10 after the WRITE above → response 0xDEADBEEF at N+3; sram_we_o stays 0 throughout.
- CAS addr 0x10, exp 0xDEADBEEF, data 0x1 → response 0xDEADBEEF at N+4; a following READ returns 0x1. With stats enabled, cas_ok_cnt_o = 1.
- CAS addr 0x10, exp 0x5, data 0x7 (memory holds 0x1) → response 0x1 at N+3; no sram write occurs. With stats enabled, cas_fail_cnt_o = 1.
- mem_rsp_rdy_i held at 0 for 5 cycles while in RSP → val and data stable; mem_req_rdy_o = 0 until 1 cycle after the handshake.
- Assert rst_i during WAIT of a matching CAS → no sram write, no response; mem_req_rdy_o = 1 while in reset, memory value unchanged.
